// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the counter primitives.
// Direction and limit-mode encodings match the dir/sat input pins.
package ctr_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Number of bits needed to hold values 0..v-1 (minimum 1).
  function automatic int ctr_clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_updown_counter_bin2gray.sv
// Parametrised binary-to-Gray converter, purely combinational.
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with wrap/saturate mode, clear, load and enable.
// Provides combinational terminal count, a registered wrap pulse and a registered Gray copy.
module mod_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  // Priority clr > load > en; saturation falls out of the default hold.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (clr) begin
      w_next_count = '0;
    end else if (load) begin
      w_next_count = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (r_count != MAX_C) begin
          w_next_count = r_count + ONE;
        end else if (sat == MODE_WRAP) begin
          w_next_count = '0;
          w_next_wrap  = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_next_count = r_count - ONE;
        end else if (sat == MODE_WRAP) begin
          w_next_count = MAX_C;
          w_next_wrap  = 1'b1;
        end
      end
    end
  end

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (w_next_count),
    .o_gray (w_next_gray)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_gray  <= w_next_gray;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count = r_count;
  assign gray  = r_gray;
  assign wrap  = r_wrap;
  assign tc    = en & ((dir == DIR_UP) ? (r_count == MAX_C) : (r_count == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: MOD=10 and MOD=16 counters plus a two-stage cascade on one clock.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // Decade counter instance (modulus 10)
  logic       a_en, a_clr, a_load, a_dir, a_sat;
  logic [3:0] a_load_val, a_count, a_gray;
  logic       a_tc, a_wrap;
  // Full-range 4-bit instance (modulus 16)
  logic       b_en, b_clr, b_load, b_dir, b_sat;
  logic [3:0] b_load_val, b_count, b_gray;
  logic       b_tc, b_wrap;
  // cascade
  logic       c_lo_en;
  logic [3:0] c_lo_count, c_lo_gray, c_hi_count, c_hi_gray;
  logic       c_lo_tc, c_lo_wrap, c_hi_tc, c_hi_wrap;

  mod_updown_counter #(.WIDTH(4), .MOD(10)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .dir(a_dir), .sat(a_sat), .count(a_count), .gray(a_gray), .tc(a_tc), .wrap(a_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MOD(16)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .dir(b_dir), .sat(b_sat), .count(b_count), .gray(b_gray), .tc(b_tc), .wrap(b_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MOD(16)) u_lo (
    .clk(clk), .rst(rst), .en(c_lo_en), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .dir(1'b1), .sat(1'b0), .count(c_lo_count), .gray(c_lo_gray), .tc(c_lo_tc), .wrap(c_lo_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MOD(16)) u_hi (
    .clk(clk), .rst(rst), .en(c_lo_tc), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .dir(1'b1), .sat(1'b0), .count(c_hi_count), .gray(c_hi_gray), .tc(c_hi_tc), .wrap(c_hi_wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [3:0] up_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] dn_seq [5]  = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] dt_seq [4]  = '{4'd6, 4'd5, 4'd6, 4'd5};
  logic [3:0] exp_c;
  logic [3:0] prev_gray;
  logic [7:0] exp_cas;

  initial begin
    rst = 1'b0;
    a_en = 0; a_clr = 0; a_load = 0; a_dir = 1; a_sat = 0; a_load_val = 0;
    b_en = 0; b_clr = 0; b_load = 0; b_dir = 1; b_sat = 0; b_load_val = 0;
    c_lo_en = 0;
    #2;
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    chk("rst_b_gray", b_gray, 0);
    chk("rst_b_wrap", b_wrap, 0);
    step();
    rst = 1'b1;

    // Asynchronous reset mid-cycle at count=9
    b_load = 1; b_load_val = 4'd9;
    step();
    b_load = 0;
    chk("b_load9", b_count, 9);
    chk("b_load9_gray", b_gray, 4'd13);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_count", b_count, 0);
    chk("async_rst_gray", b_gray, 0);
    chk("async_rst_wrap", b_wrap, 0);
    rst = 1'b1;

    // Up wrap, MOD=10
    a_en = 1; a_dir = 1; a_sat = 0;
    chk("upw_start_tc", a_tc, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("upw_count", a_count, up_seq[k]);
      chk("upw_tc", a_tc, (up_seq[k] == 4'd9));
      chk("upw_wrap", a_wrap, (k == 9));
    end
    a_en = 0;

    // Down saturate, MOD=10
    a_load = 1; a_load_val = 4'd2;
    step();
    a_load = 0;
    chk("dns_load", a_count, 2);
    a_dir = 0; a_sat = 1; a_en = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dns_count", a_count, dn_seq[k]);
      chk("dns_tc", a_tc, (dn_seq[k] == 4'd0));
      chk("dns_wrap", a_wrap, 0);
    end

    // Down wrap from 0
    a_sat = 0;
    step();
    chk("dnw_count", a_count, 9);
    chk("dnw_wrap", a_wrap, 1);
    // Up saturate at MOD-1
    a_dir = 1; a_sat = 1;
    step();
    chk("ups_count", a_count, 9);
    chk("ups_tc", a_tc, 1);
    chk("ups_wrap", a_wrap, 0);
    a_en = 0;

    // Load clamp and clr priority
    a_load = 1; a_load_val = 4'd13;
    step();
    chk("clamp_count", a_count, 9);
    a_clr = 1; a_load = 1; a_en = 1; a_load_val = 4'd5;
    step();
    chk("clr_prio_count", a_count, 0);
    chk("clr_prio_wrap", a_wrap, 0);
    a_clr = 0;
    a_load_val = 4'd3;
    step();
    chk("load_prio_count", a_count, 3);

    // Enable hold and direction change
    a_load_val = 4'd5;
    step();
    a_load = 0; a_en = 0;
    chk("hold_load", a_count, 5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_count", a_count, 5);
      chk("hold_tc", a_tc, 0);
    end
    a_en = 1;
    for (int k = 0; k < 4; k++) begin
      a_dir = (k % 2 == 0);
      step();
      chk("dirtog_count", a_count, dt_seq[k]);
    end
    a_en = 0;

    // Gray sweep, MOD=16
    b_en = 1; b_dir = 1; b_sat = 0;
    prev_gray = b_gray;
    for (int k = 1; k <= 16; k++) begin
      exp_c = 4'(k);
      step();
      chk("gray_count", b_count, exp_c);
      chk("gray_code", b_gray, exp_c ^ (exp_c >> 1));
      chk("gray_onebit", $countones(b_gray ^ prev_gray), 1);
      chk("gray_wrap", b_wrap, (k == 16));
      prev_gray = b_gray;
    end
    b_en = 0;

    // Cascade: low tc enables high stage
    chk("cas_start", {c_hi_count, c_lo_count}, 0);
    c_lo_en = 1;
    for (int k = 1; k <= 256; k++) begin
      exp_cas = 8'(k);
      step();
      chk("cas_count", {c_hi_count, c_lo_count}, exp_cas);
    end
    c_lo_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
